// File: rtl/iotdf_pkg.sv
// Shared constants for the iotdf streaming filter: function-select codes
// and the byte-wise FIR coefficients.
package iotdf_pkg;

  // fn_sel codes; 3'b111 also means passthrough and falls to the default arm.
  localparam logic [2:0] FN_PASS = 3'b000;
  localparam logic [2:0] FN_G2B  = 3'b001;
  localparam logic [2:0] FN_B2G  = 3'b010;
  localparam logic [2:0] FN_FIR  = 3'b011;
  localparam logic [2:0] FN_MAX  = 3'b100;
  localparam logic [2:0] FN_MIN  = 3'b101;
  localparam logic [2:0] FN_AVG  = 3'b110;

  // y[n] = (C0*x[n] + C1*x[n-1] + C2*x[n-2] + RND) >> SHIFT
  localparam int unsigned FIR_C0    = 5;
  localparam int unsigned FIR_C1    = 9;
  localparam int unsigned FIR_C2    = 2;
  localparam int unsigned FIR_RND   = 8;
  localparam int unsigned FIR_SHIFT = 4;

  // Reduction modes accumulate over a batch instead of producing a result per word.
  function automatic logic is_reduction(input logic [2:0] fn);
    return (fn == FN_MAX) || (fn == FN_MIN) || (fn == FN_AVG);
  endfunction

endpackage

// File: rtl/iotdf_fir.sv
// Byte-wise 3-tap FIR across the bytes of one word, MSB byte first.
// Taps before the first byte of the word are zero; nothing carries between words.
module iotdf_fir
  import iotdf_pkg::*;
#(
  parameter  int BYTES = 16,
  localparam int W     = 8 * BYTES
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  // Two zero taps prepended so every output byte uses the same expression.
  always_comb begin
    logic [7:0]  taps [BYTES+2];
    logic [11:0] sum;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    dout    = '0;
    sum     = '0;
    taps[0] = '0;
    taps[1] = '0;
    for (int n = 0; n < BYTES; n++) begin
      taps[n+2] = din[W-1-8*n -: 8];
    end
    // The 12-bit sum peaks at 16*255+8, so it never overflows.
    for (int n = 0; n < BYTES; n++) begin
      sum = 12'(FIR_C0) * {4'd0, taps[n+2]}
          + 12'(FIR_C1) * {4'd0, taps[n+1]}
          + 12'(FIR_C2) * {4'd0, taps[n]}
          + 12'(FIR_RND);
      dout[W-1-8*n -: 8] = 8'(sum >> FIR_SHIFT);
    end
  end

endmodule

// File: rtl/iotdf_stream.sv
// Streaming IoT data filter: assembles bytes into W-bit words (MSB first),
// then applies a per-word transform or a per-batch max/min/avg reduction.
// One busy cycle follows every completed word; results are registered.
module iotdf_stream
  import iotdf_pkg::*;
#(
  parameter  int BYTES = 16,
  parameter  int BATCH = 8,
  localparam int W     = 8 * BYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_en,
  input  logic [7:0]   iot_in,
  input  logic [2:0]   fn_sel,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] iot_out
);

  localparam int LB = $clog2(BATCH);
  localparam int CW = $clog2(BYTES);
  localparam int AW = W + LB;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_PROC    = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] byte_cnt;
  logic [W-9:0]  word;        // first BYTES-1 bytes; the last byte comes straight from iot_in
  logic [2:0]    word_mode;
  logic [2:0]    prev_mode;
  logic [LB-1:0] batch_cnt;
  logic [AW-1:0] acc;

  logic          capture, last_byte, reduce, restart, batch_done;
  logic [2:0]    mode_now;
  logic [W-1:0]  full_word, fir_out, word_result;
  logic [LB-1:0] cnt_eff;
  logic [AW-1:0] acc_eff, acc_next;

  // Bit i of the binary value is the XOR of all gray bits at or above i.
  function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  assign busy      = (state == ST_PROC);
  assign capture   = in_en && (state == ST_COLLECT);
  assign last_byte = capture && (byte_cnt == CW'(BYTES - 1));
  // Mode is taken live on byte 0 and from the held copy afterwards.
  assign mode_now  = (byte_cnt == '0) ? fn_sel : word_mode;
  assign full_word = {word, iot_in};
  assign reduce    = is_reduction(mode_now);

  iotdf_fir #(.BYTES(BYTES)) u_fir (
    .din  (full_word),
    .dout (fir_out)
  );

  // Next batch accumulator; a mode change restarts the batch at this word.
  always_comb begin
    restart    = (mode_now != prev_mode);
    cnt_eff    = restart ? '0 : batch_cnt;
    acc_eff    = restart ? '0 : acc;
    batch_done = (cnt_eff == LB'(BATCH - 1));
    acc_next   = acc_eff;
    case (mode_now)
      FN_MAX:  if (cnt_eff == '0 || AW'(full_word) > acc_eff) acc_next = AW'(full_word);
      FN_MIN:  if (cnt_eff == '0 || AW'(full_word) < acc_eff) acc_next = AW'(full_word);
      FN_AVG:  acc_next = acc_eff + AW'(full_word);
      default: acc_next = acc_eff;
    endcase
  end

  // Result selection for the word completing this edge.
  always_comb begin
    word_result = full_word;
    case (mode_now)
      FN_G2B:         word_result = gray_to_bin(full_word);
      FN_B2G:         word_result = full_word ^ (full_word >> 1);
      FN_FIR:         word_result = fir_out;
      FN_MAX, FN_MIN: word_result = acc_next[W-1:0];
      FN_AVG:         word_result = acc_next[AW-1:LB];
      default:        word_result = full_word;
    endcase
  end

  // Capture FSM, batch state and the registered output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_COLLECT;
      byte_cnt  <= '0;
      word      <= '0;
      word_mode <= FN_PASS;
      prev_mode <= FN_PASS;
      batch_cnt <= '0;
      acc       <= '0;
      valid     <= 1'b0;
      iot_out   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
      valid <= 1'b0;
      case (state)
        ST_PROC: state <= ST_COLLECT;
        default: begin
          if (capture) begin
            if (byte_cnt == '0) word_mode <= fn_sel;
            if (last_byte) begin
              byte_cnt  <= '0;
              word      <= '0;
              state     <= ST_PROC;
              prev_mode <= mode_now;
              if (!reduce) begin
                valid   <= 1'b1;
                iot_out <= word_result;
              end else if (batch_done) begin
                batch_cnt <= '0;
                acc       <= '0;
                valid     <= 1'b1;
                iot_out   <= word_result;
              end else begin
                batch_cnt <= cnt_eff + 1'b1;
                acc       <= acc_next;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              word     <= full_word[W-9:0];
            end
          end
        end
      endcase
    end
  end

endmodule
